// File: rtl/i2s_mstr.sv
// I2S transmitter (bus master).
// Serialises a parallel 24-bit left/right sample pair into I2S_sclk / I2S_ws /
// I2S_data. It asks upstream for the next pair with smpl_req once per
// 64-slot frame. Every output is a flop, so nothing glitches on the wire.
// SCLK_HALF must be 2 or more.
module i2s_mstr #(
  parameter int SCLK_HALF = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] lft_chnnl,
  input  logic [23:0] rght_chnnl,
  output logic        smpl_req,
  output logic        I2S_sclk,
  output logic        I2S_ws,
  output logic        I2S_data
);

  localparam int DIV_MAX = 2 * SCLK_HALF - 1;
  localparam int DIV_W   = $clog2(2 * SCLK_HALF);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             fall;
  logic             sclk_nxt;

  logic [5:0]       slot;
  logic [5:0]       slot_nxt;
  logic             cap;
  logic             ws_nxt;

  logic [23:0]      lft_sr;
  logic [23:0]      rght_sr;
  logic [23:0]      src_l;
  logic [23:0]      src_r;
  logic [4:0]       bit_idx;
  logic             data_nxt;

  logic             sclk_q;
  logic             ws_q;
  logic             data_q;
  logic             req_q;

  // Divider next state. sclk is registered from the next count so that it
  // always equals (div_cnt >= SCLK_HALF) while still coming from a flop.
  always_comb begin
    fall     = (div_cnt == DIV_W'(DIV_MAX));
    div_nxt  = fall ? '0 : div_cnt + 1'b1;
    sclk_nxt = (div_nxt >= DIV_W'(SCLK_HALF));
  end

  // Slot, capture and bit-select decode for the upcoming fall edge.
  // A capture edge serialises straight from the inputs, so the left MSB
  // reaches the wire on the same edge that loads the holding registers.
  always_comb begin
    slot_nxt = slot + 6'd1;
    cap      = fall && (slot == 6'd63);
    ws_nxt   = (slot_nxt >= 6'd31) && (slot_nxt != 6'd63);
    src_l    = cap ? lft_chnnl  : lft_sr;
    src_r    = cap ? rght_chnnl : rght_sr;
    // Slots 0-23 and 32-55 share the same low five bits, so one index
    // serves both channels; slots with bits [4:3] = 2'b11 are pad slots.
    bit_idx  = 5'd23 - slot_nxt[4:0];
    data_nxt = 1'b0;
    if (slot_nxt[4:3] != 2'b11) begin
      data_nxt = slot_nxt[5] ? src_r[bit_idx] : src_l[bit_idx];
    end
  end

  // Bit-clock divider and registered sclk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk_q  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      sclk_q  <= sclk_nxt;
    end
  end

  // Slot counter, word select and serial data, all moved on sclk fall only.
  // Reset parks the slot at 63 so the first fall edge opens a clean frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= 6'd63;
      ws_q   <= 1'b0;
      data_q <= 1'b0;
    end else if (fall) begin
      slot   <= slot_nxt;
      ws_q   <= ws_nxt;
      data_q <= data_nxt;
    end
  end

  // Sample-pair holding registers, loaded only at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_sr  <= '0;
      rght_sr <= '0;
    end else if (cap) begin
      lft_sr  <= lft_chnnl;
      rght_sr <= rght_chnnl;
    end
  end

  // One-cycle request pulse in the cycle following a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else begin
      req_q <= cap;
    end
  end

  assign I2S_sclk = sclk_q;
  assign I2S_ws   = ws_q;
  assign I2S_data = data_q;
  assign smpl_req = req_q;

endmodule

// File: tb/tb_i2s_mstr.sv
// Self-checking bench for i2s_mstr. A time-based reference model derives
// every expected output from the number of clk edges since reset release.
module tb_i2s_mstr;

  localparam int H  = 16;
  localparam int P  = 2 * H;
  localparam int FR = 128 * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] lft = '0;
  logic [23:0] rght = '0;
  logic        smpl_req;
  logic        sclk;
  logic        ws;
  logic        data;

  int total = 0;
  int bad = 0;

  // model state
  int          t;
  logic [23:0] cap_l, cap_r;
  int          last_req;
  int          ws_run;
  logic        ws_prev, sclk_prev;
  logic [23:0] rx_l, rx_r;

  i2s_mstr #(.SCLK_HALF(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lft_chnnl (lft),
    .rght_chnnl(rght),
    .smpl_req  (smpl_req),
    .I2S_sclk  (sclk),
    .I2S_ws    (ws),
    .I2S_data  (data)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, obs, exp);
    end
  endtask

  // slot in force after edge tt: 63 until the first fall, then one per fall
  function automatic int slot_of(input int tt);
    int n;
    n = tt / P;
    return (n == 0) ? 63 : (n - 1) % 64;
  endfunction

  task automatic model_reset();
    t         = 0;
    cap_l     = '0;
    cap_r     = '0;
    last_req  = -1;
    ws_run    = 0;
    ws_prev   = 1'b0;
    sclk_prev = 1'b0;
    rx_l      = '0;
    rx_r      = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk_eq({tag, "_sclk"}, 32'(sclk), 32'd0);
    chk_eq({tag, "_ws"},   32'(ws),   32'd0);
    chk_eq({tag, "_data"}, 32'(data), 32'd0);
    chk_eq({tag, "_req"},  32'(smpl_req), 32'd0);
  endtask

  // one clk cycle: advance the model at the edge, check at the negedge
  task automatic cyc();
    int   s;
    logic capt, e_sclk, e_ws, e_data;
    @(posedge clk);
    t++;
    capt = (t % P == 0) && (slot_of(t) == 0);
    if (capt) begin
      cap_l = lft;
      cap_r = rght;
    end
    @(negedge clk);
    s      = slot_of(t);
    e_sclk = (t % P) >= H;
    e_ws   = (((s + 1) % 64) >= 32);
    if (s < 24)                 e_data = cap_l[23 - s];
    else if (s >= 32 && s < 56) e_data = cap_r[55 - s];
    else                        e_data = 1'b0;
    chk_eq("sclk", 32'(sclk), 32'(e_sclk));
    chk_eq("ws",   32'(ws),   32'(e_ws));
    chk_eq("data", 32'(data), 32'(e_data));
    chk_eq("req",  32'(smpl_req), 32'(capt));

    if (smpl_req) begin
      if (last_req < 0) chk_eq("first_req", 32'(t), 32'(P));
      else              chk_eq("req_gap", 32'(t - last_req), 32'(FR));
      last_req = t;
    end
    if (ws !== ws_prev) chk_eq("ws_edge_phase", 32'(t % P), 32'd0);
    if (ws) ws_run++;
    else begin
      if (ws_prev) chk_eq("ws_high_len", 32'(ws_run), 32'(FR / 2));
      ws_run = 0;
    end
    if (sclk && !sclk_prev) begin
      if (s < 24) begin
        rx_l = {rx_l[22:0], data};
        if (s == 23) chk_eq("rx_left", 32'(rx_l), 32'(cap_l));
      end else if (s >= 32 && s < 56) begin
        rx_r = {rx_r[22:0], data};
        if (s == 55) chk_eq("rx_right", 32'(rx_r), 32'(cap_r));
      end
    end
    ws_prev   = ws;
    sclk_prev = sclk;
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      chk_zero("rst");
    end

    // first frame: fixed pattern, then inputs change at slot 10
    lft   = 24'hA55AF0;
    rght  = 24'h0FF0C3;
    rst_n = 1'b1;
    guard = 0;
    while (!(t > P && slot_of(t) == 10) && guard < 4 * FR) begin
      cyc();
      guard++;
    end
    chk_eq("reach_slot10", 32'(guard < 4 * FR), 32'd1);
    lft  = 24'hFFFFFF;
    rght = 24'hFFFFFF;
    while (t < 3 * FR + 2 * P) cyc();

    // random pairs, refreshed on request and at random moments mid-frame
    repeat (3 * FR) begin
      cyc();
      if (smpl_req || $urandom_range(0, 199) == 0) begin
        lft  = 24'($urandom);
        rght = 24'($urandom);
      end
    end

    // asynchronous reset in the middle of a right-channel word
    guard = 0;
    while (slot_of(t) != 40 && guard < 2 * FR) begin
      cyc();
      guard++;
    end
    chk_eq("reach_slot40", 32'(guard < 2 * FR), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_zero("rst_hold");
    model_reset();
    lft   = 24'h123456;
    rght  = 24'h800001;
    rst_n = 1'b1;
    repeat (FR + 4 * P) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_mstr.md
# i2s_mstr

I2S transmitter (bus master) for the equalizer: generates `I2S_sclk`, `I2S_ws` and `I2S_data` from parallel 24-bit left/right samples. It is the transmit-side counterpart of the I2S receiver that feeds `EQ_Engine`. It drives a downstream I2S codec/DAC, and it also serves as a bench stimulus source for the receiver. It owns all I2S timing and requests a new sample pair once per frame.

## Interface
- `SCLK_HALF`, default 16: `clk` cycles per `I2S_sclk` half-period; legal values are 2 or more. The default gives a 1.5625 MHz sclk from a 50 MHz `clk`.
- `clk` input, 1 bit: system clock. This is the only clock.
- `rst_n` input, 1 bit: asynchronous active-low reset from `rst_synch`.
- `lft_chnnl` input, 24 bits: left sample, two's complement. Sampled only at the capture edge.
- `rght_chnnl` input, 24 bits: right sample, two's complement. Sampled at the same capture edge as `lft_chnnl`.
- `smpl_req` output, 1 bit: one-`clk` pulse the cycle after a sample pair is captured. Upstream then presents the next pair.
- `I2S_sclk` output, 1 bit: serial bit clock.
- `I2S_ws` output, 1 bit: word select; 0 = left, 1 = right.
- `I2S_data` output, 1 bit: serial data, MSB first.

## Operation
- **Clock divider.** `div_cnt` counts 0 to 2·SCLK_HALF−1 and wraps.
  - `I2S_sclk` = 0 while `div_cnt` < SCLK_HALF, else 1.
  - A "fall edge" is the `clk` edge on which `div_cnt` wraps to 0.
- **Slot counter.** 6-bit `slot` counter (0–63), advanced by +1 on every fall edge, wrapping 63→0. One frame is 64 sclk periods.
- **Capture.**
  - Happens on the fall edge where `slot` goes 63→0.
  - `lft_chnnl` and `rght_chnnl` load into the left and right shift registers on that same `clk` edge.
  - `smpl_req` is high for exactly the following `clk` cycle.
  - No other edge samples the inputs.
- **Data mapping**, updated only on fall edges:
  - `slot` 0–23: left[23−slot].
  - `slot` 24–31: 0.
  - `slot` 32–55: right[55−slot].
  - `slot` 56–63: 0.
- **Word select.** `I2S_ws` = bit 5 of (`slot`+1), 6-bit wrap.
  - It is 0 for slots 63, 0–30 and 1 for slots 31–62.
  - So `I2S_ws` changes one sclk before each channel's MSB, per the standard I2S convention.
- **Output quality.** All outputs come straight from flops or from a decode of a single flop bit, so they are glitch-free.
  - `I2S_ws` and `I2S_data` change only on the `clk` edge that drops `I2S_sclk`.
  - A receiver sampling on sclk rise therefore sees SCLK_HALF `clk` cycles of setup and of hold.
- **Arithmetic.** Samples are passed through unmodified; there is no rounding or sign extension. Pad bits are always 0.

## Timing
- **Reset values:**
  - `div_cnt` = 0, `slot` = 63, shift registers = 0.
  - `I2S_sclk` = 0, `I2S_ws` = 0, `I2S_data` = 0, `smpl_req` = 0.
- **Reset is asynchronous** and takes effect immediately, including mid-frame. On release, the sequence restarts from the reset state, and the first frame always begins cleanly at slot 0.
- **After release:**
  - First sclk rise occurs SCLK_HALF `clk` edges after reset release.
  - First fall/capture edge (`slot` 63→0) occurs 2·SCLK_HALF edges after release.
  - `smpl_req` is high in the cycle immediately after the capture edge.
  - At that capture edge `I2S_data` = `lft_chnnl`[23] (the value sampled at that edge).
- **Periods:**
  - sclk period = 2·SCLK_HALF clk, duty 50%.
  - Frame = 128·SCLK_HALF clk (2048 at default, i.e. 24.414 kHz at 50 MHz).
  - `smpl_req` period = one frame.
- **Latency.** Capture to left MSB on the wire: 0 cycles. Capture to right MSB: 32 sclk periods.
- **Upstream window.** Upstream has 128·SCLK_HALF−1 `clk` cycles after `smpl_req` to settle the next pair. Input changes at any other time have no effect on the current frame.
- **Back-pressure.** There is none. If upstream fails to update, the held values are re-sent.

## Test plan
- **Reset and first frame.** Hold `rst_n`=0, then release with default parameters.
  - During reset, all outputs are 0.
  - `I2S_sclk` rises at clk 16 and falls at clk 32.
  - `smpl_req` pulses at cycle 33 only.
- **Periods.** Run 3 frames.
  - sclk high/low = 16/16 clk.
  - `I2S_ws` low 1024 clk / high 1024 clk, with edges coincident with sclk falls.
  - `smpl_req` spacing = 2048 clk.
- **Bit mapping.** Use `lft_chnnl`=24'hA55AF0 and `rght_chnnl`=24'h0FF0C3.
  - Bits sampled at sclk rises in slots 0–23 = A55AF0, MSB first.
  - Slots 24–31 = 0.
  - Slots 32–55 = 0FF0C3.
  - Slots 56–63 = 0.
- **Input isolation.** Change both inputs to 24'hFFFFFF at slot 10.
  - The current frame is unaffected.
  - The next frame carries FFFFFF on both channels.
- **Loopback.** Connect to `I2S_Serf` with a new pair each `smpl_req` (0x000001, 0x800000, 0x7FFFFF, …).
  - Every receiver `vld` shows `lft_chnnl`/`rght_chnnl` equal to the pair captured one frame earlier.
- **Mid-frame reset.** Assert `rst_n`=0 at slot 40 for 5 clk.
  - Outputs go to 0 asynchronously.
  - The restart timing is identical to the first scenario.
